// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of a single-port byte-addressed data
// memory (big-endian words, combinational read, write on the falling edge).
// Each access runs IDLE -> ACCESS -> RESP, one cycle per state, and any
// out-of-range or misaligned address is rejected before the memory sees it.
module dm_arbiter #(
   parameter int DEPTH_BYTES    = 64,
   parameter int FIXED_PRIORITY = 0,
   parameter int CHECK_ALIGN    = 1
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        err0,
   output logic        ack1,
   output logic        err1,
   output logic [31:0] rdata,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   // Highest byte address at which a full word still fits in the array.
   localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

   logic [1:0]  state;
   logic        last_grant;
   logic        lat_port;
   logic        lat_we;
   logic        lat_err;

   logic        win;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic        win_err;

   // Pick the winning port and validate its address; only consumed in IDLE.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
         win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      end else if (req1) begin
         win = 1'b1;
      end
      win_we    = win ? we1    : we0;
      win_addr  = win ? addr1  : addr0;
      win_wdata = win ? wdata1 : wdata0;
      // Plain unsigned compare against the last word start: no addr+3 is
      // formed, so addresses near 0xFFFFFFFF cannot wrap into range.
      win_err   = (win_addr > LAST_WORD) ||
                  ((CHECK_ALIGN != 0) && (win_addr[1:0] != 2'b00));
   end

   // Handshake sequencer; every output is a register updated here.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other, independent of statement order.
      if (Reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_port   <= 1'b0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         ack0       <= 1'b0;
         err0       <= 1'b0;
         ack1       <= 1'b0;
         err1       <= 1'b0;
         rdata      <= 32'h0;
         mem_rw     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state      <= ACCESS;
                  last_grant <= win;
                  lat_port   <= win;
                  lat_we     <= win_we;
                  lat_err    <= win_err;
                  // A rejected access parks the address at 0 and never writes.
                  mem_addr   <= win_err ? 32'h0 : win_addr;
                  mem_wdata  <= win_wdata;
                  mem_rw     <= win_we & ~win_err;
               end
            end
            ACCESS: begin
               state  <= RESP;
               mem_rw <= 1'b0;
               rdata  <= (lat_we || lat_err) ? 32'h0 : mem_rdata;
               ack0   <= ~lat_port;
               err0   <= ~lat_port & lat_err;
               ack1   <= lat_port;
               err1   <= lat_port & lat_err;
            end
            RESP: begin
               state <= IDLE;
               ack0  <= 1'b0;
               err0  <= 1'b0;
               ack1  <= 1'b0;
               err1  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Arbitrates the single-port byte-addressed data memory (big-endian 32-bit words, combinational read, write on falling CLK edge) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the debug/loader path.
- Sequences each access through a fixed 3-state handshake and drives the memory's DataMemRW/DAddr/DataIn.
- Rejects out-of-range or misaligned accesses so the memory array is never indexed past its end.

Parameters:
- DEPTH_BYTES, 64, memory size in bytes; valid word addresses are 0..DEPTH_BYTES-4.
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins.
- CHECK_ALIGN, 1, 1 = addr[1:0]!=0 is an error; 0 = only the range is checked.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, port 0 / port 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack; access was rejected.
- rdata  out  32  read data, shared by both ports; valid while either ack is high.
- mem_rw  out  1  to memory DataMemRW.
- mem_addr  out  32  to memory DAddr.
- mem_wdata  out  32  to memory DataIn.
- mem_rdata  in  32  from memory DataOut.

Behaviour:
- All outputs are registered. Reset values: ack0=ack1=0, err0=err1=0, rdata=0, mem_rw=0, mem_addr=0, mem_wdata=0, state=IDLE, last_grant=1 (so port 0 wins first).
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick a winner:
    - Only one port requesting: that port wins.
    - Both requesting, FIXED_PRIORITY=1: port 0 wins.
    - Both requesting, round-robin: the port != last_grant wins.
  - Latch the winner's we, addr and wdata; set last_grant = winner.
  - Compute err = (addr > DEPTH_BYTES-4) | (CHECK_ALIGN & (addr[1:0]!=0)). Do the compare in 32 bits unsigned; do not form addr+3, so there is no wrap at 0xFFFFFFFD..0xFFFFFFFF.
  - Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr and mem_wdata = latched wdata, stable for the whole cycle.
  - mem_rw = latched we & ~err; the memory commits at the falling edge inside this cycle.
  - On err, mem_addr is forced to 0.
  - At the rising edge ending ACCESS: capture rdata = (we|err) ? 0 : mem_rdata; set ack/err of the winner; mem_rw=0; go to RESP.
- RESP (1 cycle):
  - ackN=1 and errN as computed; rdata holds.
  - Next state is IDLE; ack and err clear on leaving RESP.
  - rdata holds its value until the next capture.
- mem_rw is 0 in every cycle except ACCESS. mem_addr and mem_wdata hold their last values outside ACCESS.
- Latency: req sampled high at rising edge T, ack high during cycle T+2. Throughput is 1 access per 3 cycles.
- Requester holds req/we/addr/wdata until ack. After the edge of acceptance the arbiter ignores changes; if req drops after acceptance, the access still completes and acks.
- req still high in the cycle after ack is treated as a new request (re-arbitrated in IDLE).
- The losing port waits; it gets the next grant under round-robin even if the winner re-requests immediately.
- Reset mid-operation:
  - Reset asserted at the edge ending ACCESS: the write already committed at the falling edge stands; no ack is issued; all outputs take reset values.
  - Reset in RESP: the ack is cut to 0 at that edge.
- Simultaneous reset and req: reset wins; the request is not accepted.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF to addr 8, then reads addr 8 → mem_rw=1 only in the ACCESS cycle; ack0 at T+2; read rdata=0xDEADBEEF, err0=0.
- req0 and req1 asserted in the same cycle and held continuously (round-robin) → grants alternate 0,1,0,1; each port sees ack every 6 cycles.
- Same stimulus with FIXED_PRIORITY=1 → port 1 never acked while req0 stays high.
- Port 1 write to addr 61 (out of range), addr 0xFFFFFFFE (wrap case) and addr 6 (misaligned) → ack1 with err1=1, mem_rw stays 0, memory unchanged, rdata=0.
- Port 0 read at addr 60 (last valid word) → err0=0; data equals bytes 60..63 concatenated big-endian.
- Port 0 write to addr 4 with Reset asserted at the edge ending ACCESS → no ack; memory at 4 updated; after reset, ack0=0, mem_rw=0, and the next grant goes to port 0.
